// File: rtl/signal_phase_ctrl_if.sv
// ============================================================================
// Module      : signal_phase_ctrl_if
// Description : Sensor-average inputs and signal-head outputs of the phase
//               controller, bundled with master (sensor/TB side) and slave
//               (controller side) views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signal_phase_ctrl_if;
    logic [7:0] avg_n;
    logic [7:0] avg_e;
    logic [7:0] avg_s;
    logic [7:0] avg_w;
    logic       avg_valid;
    logic [1:0] light_n;
    logic [1:0] light_e;
    logic [1:0] light_s;
    logic [1:0] light_w;
    logic [1:0] cur_dir;
    logic [1:0] fsm_state;
    logic       sample_req;

    modport master (
        output avg_n, avg_e, avg_s, avg_w, avg_valid,
        input  light_n, light_e, light_s, light_w, cur_dir, fsm_state, sample_req
    );

    modport slave (
        input  avg_n, avg_e, avg_s, avg_w, avg_valid,
        output light_n, light_e, light_s, light_w, cur_dir, fsm_state, sample_req
    );
endinterface

`default_nettype wire

// File: rtl/signal_phase_ctrl.sv
// ============================================================================
// Module      : signal_phase_ctrl
// Description : Four-way round-robin traffic phase controller; green length
//               scales with each direction's registered moving average.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_phase_ctrl #(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 60,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int TW        = 9
) (
    input  wire logic          clk,
    input  wire logic          reset,
    signal_phase_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } state_t;

    localparam logic [1:0]    c_RED      = 2'b00;
    localparam logic [1:0]    c_YEL      = 2'b01;
    localparam logic [1:0]    c_GRN      = 2'b10;
    localparam logic [TW-1:0] c_ALLRED_T = TW'(ALLRED_T);
    localparam logic [TW-1:0] c_YELLOW_T = TW'(YELLOW_T);
    localparam logic [TW-1:0] c_MIN_G    = TW'(MIN_GREEN);
    localparam logic [TW-1:0] c_MAX_G    = TW'(MAX_GREEN);
    localparam logic [TW-1:0] c_ONE      = TW'(1);

    state_t        r_state;
    state_t        w_state_nx;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nx;
    logic [1:0]    r_dir;
    logic [1:0]    w_dir_nx;
    logic          r_req;
    logic          w_req_nx;
    logic [7:0]    r_avg [4];

    logic [1:0]    w_sel;
    logic [1:0]    w_cand;
    logic          w_found;
    logic [7:0]    w_avg_sel;
    logic [TW-1:0] w_sum;
    logic [TW-1:0] w_glen;
    logic [1:0]    w_light [4];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_ALLRED;
            r_timer <= c_ALLRED_T;
            r_dir   <= 2'd3;
            r_req   <= 1'b0;
            for (int i = 0; i < 4; i++) r_avg[i] <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_dir   <= w_dir_nx;
            r_req   <= w_req_nx;
            if (bus.avg_valid) begin
                r_avg[0] <= bus.avg_n;
                r_avg[1] <= bus.avg_e;
                r_avg[2] <= bus.avg_s;
                r_avg[3] <= bus.avg_w;
            end
        end
    end

    // First non-zero direction after the current one; wraps back to itself last.
    always_comb begin
        w_sel   = r_dir + 2'd1;
        w_cand  = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_dir + 2'(k);
            if (!w_found && (r_avg[w_cand] != 8'd0)) begin
                w_sel   = w_cand;
                w_found = 1'b1;
            end
        end
        w_avg_sel = r_avg[w_sel];
        w_sum     = c_MIN_G + {{(TW-8){1'b0}}, w_avg_sel};
        w_glen    = (w_sum > c_MAX_G) ? c_MAX_G : w_sum;
    end

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer - c_ONE;
        w_dir_nx   = r_dir;
        w_req_nx   = r_req;
        case (r_state)
            ST_ALLRED: begin
                if (r_timer == c_ONE) begin
                    w_state_nx = ST_GREEN;
                    w_timer_nx = w_glen;
                    w_dir_nx   = w_sel;
                    // A selection at or below the last direction closes a round.
                    if (w_sel <= r_dir) w_req_nx = ~r_req;
                end
            end
            ST_GREEN: begin
                if (r_timer == c_ONE) begin
                    w_state_nx = ST_YELLOW;
                    w_timer_nx = c_YELLOW_T;
                end
            end
            ST_YELLOW: begin
                if (r_timer == c_ONE) begin
                    w_state_nx = ST_ALLRED;
                    w_timer_nx = c_ALLRED_T;
                end
            end
            default: begin
                w_state_nx = ST_ALLRED;
                w_timer_nx = c_ALLRED_T;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) w_light[i] = c_RED;
        if (r_state == ST_GREEN)  w_light[r_dir] = c_GRN;
        if (r_state == ST_YELLOW) w_light[r_dir] = c_YEL;
    end

    assign bus.light_n    = w_light[0];
    assign bus.light_e    = w_light[1];
    assign bus.light_s    = w_light[2];
    assign bus.light_w    = w_light[3];
    assign bus.cur_dir    = r_dir;
    assign bus.fsm_state  = r_state;
    assign bus.sample_req = r_req;

endmodule

`default_nettype wire

// File: tb/tb_signal_phase_ctrl.sv
// ============================================================================
// Module      : tb_signal_phase_ctrl
// Description : Directed bench; expected phases (state/dir/req/length) are
//               queued per test and compared as each observed phase ends.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signal_phase_ctrl;

    localparam logic [1:0] S_AR = 2'b00;
    localparam logic [1:0] S_G  = 2'b01;
    localparam logic [1:0] S_Y  = 2'b10;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] dir;
        logic       req;
        logic [8:0] len;
    } phase_t;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    int   n_phase;

    phase_t exp_q[$];

    signal_phase_ctrl_if bus ();

    signal_phase_ctrl #(
        .MIN_GREEN (5),
        .MAX_GREEN (60),
        .YELLOW_T  (3),
        .ALLRED_T  (1),
        .TW        (9)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [1:0] dir, input logic req, input int len);
        phase_t p;
        p.st  = st;
        p.dir = dir;
        p.req = req;
        p.len = 9'(len);
        exp_q.push_back(p);
    endtask

    // Green, yellow, all-red for one served direction.
    task automatic push_service(input logic [1:0] dir, input logic req, input int glen);
        push(S_G,  dir, req, glen);
        push(S_Y,  dir, req, 3);
        push(S_AR, dir, req, 1);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lights", 32'({bus.light_w, bus.light_s, bus.light_e, bus.light_n}), 32'h0);
        check("rst_dir",    32'(bus.cur_dir),    32'd3);
        check("rst_req",    32'(bus.sample_req), 32'd0);
        check("rst_state",  32'(bus.fsm_state),  32'(S_AR));
        @(posedge clk);
        #2;
    endtask

    // Release reset with a simultaneous shadow strobe; that strobe must not
    // influence the selection made at the end of the first all-red cycle.
    task automatic release_with(input logic [7:0] n, input logic [7:0] e, input logic [7:0] s, input logic [7:0] w);
        reset         = 1'b1;
        bus.avg_n     = n;
        bus.avg_e     = e;
        bus.avg_s     = s;
        bus.avg_w     = w;
        bus.avg_valid = 1'b1;
        push(S_AR, 2'd3, 1'b0, 1);
        @(posedge clk);
        #2 bus.avg_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < budget) begin
            @(posedge clk);
            cnt++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Phase tracker and per-cycle light invariants.
    initial begin
        phase_t     cur;
        phase_t     obs;
        phase_t     e;
        logic       trk;
        logic [7:0] lexp;
        int         nonred;
        trk = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                trk = 1'b0;
            end else begin
                obs.st  = bus.fsm_state;
                obs.dir = bus.cur_dir;
                obs.req = bus.sample_req;
                obs.len = 9'd1;
                if (!trk) begin
                    cur = obs;
                    trk = 1'b1;
                end else if (obs.st == cur.st && obs.dir == cur.dir && obs.req == cur.req) begin
                    cur.len = cur.len + 9'd1;
                end else begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_phase++;
                        check($sformatf("phase%0d", n_phase), 32'(cur), 32'(e));
                    end
                    cur = obs;
                end
                lexp = 8'h0;
                if (bus.fsm_state == S_G) lexp[2*bus.cur_dir +: 2] = 2'b10;
                if (bus.fsm_state == S_Y) lexp[2*bus.cur_dir +: 2] = 2'b01;
                nonred = 0;
                if (bus.light_n != 2'b00) nonred++;
                if (bus.light_e != 2'b00) nonred++;
                if (bus.light_s != 2'b00) nonred++;
                if (bus.light_w != 2'b00) nonred++;
                check("one_light", 32'(nonred <= 1 && bus.fsm_state != 2'b11), 32'd1);
                check("lights", 32'({bus.light_w, bus.light_s, bus.light_e, bus.light_n}), 32'(lexp));
            end
        end
    end

    initial begin
        int cnt;
        n_assert      = 0;
        n_fail        = 0;
        n_phase       = 0;
        reset         = 1'b0;
        bus.avg_n     = 8'd0;
        bus.avg_e     = 8'd0;
        bus.avg_s     = 8'd0;
        bus.avg_w     = 8'd0;
        bus.avg_valid = 1'b0;

        // All shadows zero: every direction gets MIN_GREEN, toggle only at N.
        apply_reset();
        release_with(8'd0, 8'd0, 8'd0, 8'd0);
        push_service(2'd0, 1'b1, 5);
        push_service(2'd1, 1'b1, 5);
        push_service(2'd2, 1'b1, 5);
        push_service(2'd3, 1'b1, 5);
        push(S_G, 2'd0, 1'b0, 5);
        drain(200);

        // Mid-operation reset, then N=10 E=20 S=0 W=100: S skipped, W saturates.
        repeat (7) @(posedge clk);
        apply_reset();
        release_with(8'd10, 8'd20, 8'd0, 8'd100);
        push_service(2'd0, 1'b1, 5);
        push_service(2'd1, 1'b1, 25);
        push_service(2'd3, 1'b1, 60);
        push_service(2'd0, 1'b0, 15);
        push(S_G, 2'd1, 1'b0, 25);
        drain(400);

        // Only E non-zero: E served back-to-back, toggling every entry.
        apply_reset();
        release_with(8'd0, 8'd7, 8'd0, 8'd0);
        push_service(2'd0, 1'b1, 5);
        push_service(2'd1, 1'b1, 12);
        push_service(2'd1, 1'b0, 12);
        push(S_G, 2'd1, 1'b1, 12);
        drain(300);

        // Shadow update during N green leaves the running green unchanged.
        apply_reset();
        release_with(8'd10, 8'd0, 8'd0, 8'd0);
        push_service(2'd0, 1'b1, 5);
        push_service(2'd0, 1'b0, 15);
        push_service(2'd1, 1'b0, 14);
        push(S_G, 2'd0, 1'b1, 60);
        cnt = 0;
        while (!(bus.fsm_state == S_G && bus.cur_dir == 2'd0 && bus.sample_req == 1'b0) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("wait_n_green", 32'(cnt < 100), 32'd1);
        @(posedge clk);
        #2;
        bus.avg_n     = 8'd200;
        bus.avg_e     = 8'd9;
        bus.avg_valid = 1'b1;
        @(posedge clk);
        #2 bus.avg_valid = 1'b0;
        drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
